// File: rtl/notedur_pkg.sv
// Shared types and helpers for the note-duration tracker.
// Provides the one-hot duration class encoding, the rest code and the
// frame-count classifier used when an event is emitted.
package notedur_pkg;

  localparam int unsigned DUR_W     = 4;
  localparam int unsigned REST_CODE = 0;

  typedef enum logic [3:0] {
    DUR_SHORT   = 4'b0000,
    DUR_EIGHTH  = 4'b0001,
    DUR_QUARTER = 4'b0010,
    DUR_HALF    = 4'b0100,
    DUR_WHOLE   = 4'b1000
  } dur_class_t;

  // Map a frame count onto the longest class whose threshold it reaches.
  function automatic dur_class_t classify(input int unsigned frames,
                                          input int unsigned t_eighth,
                                          input int unsigned t_quarter,
                                          input int unsigned t_half,
                                          input int unsigned t_whole);
    if (frames < t_eighth)  return DUR_SHORT;
    if (frames < t_quarter) return DUR_EIGHTH;
    if (frames < t_half)    return DUR_QUARTER;
    if (frames < t_whole)   return DUR_HALF;
    return DUR_WHOLE;
  endfunction

endpackage

// File: rtl/notedur_tracker_if.sv
// Event stream from the tracker to the score/display logic.
// out_valid/out_ready handshake plus the {note, class, frames} payload.
interface notedur_tracker_if #(
  parameter int unsigned NOTE_W = 8,
  parameter int unsigned CNT_W  = 6
);
  logic                           out_valid;
  logic                           out_ready;
  logic [NOTE_W-1:0]              out_note;
  logic [notedur_pkg::DUR_W-1:0]  out_dur;
  logic [CNT_W-1:0]               out_frames;

  modport master (output out_valid, out_note, out_dur, out_frames, input out_ready);
  modport slave  (input out_valid, out_note, out_dur, out_frames, output out_ready);
endinterface

// File: rtl/note_event_fifo.sv
// First-word-fall-through sync FIFO for completed note events.
// Ports: clk, reset (async active-low), push/push_data, pop,
//        head/head_valid (registered head word), full, empty.
// The head word lives in its own register so it holds its last value
// once the FIFO drains.
module note_event_fifo #(
  parameter int unsigned WIDTH = 18,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             head_valid,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_n_c;
  logic [WIDTH-1:0] head_n_c;
  logic             pop_ok_c;
  logic             push_ok_c;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  always_comb begin
    pop_ok_c  = pop && !empty;
    push_ok_c = push && (!full || pop_ok_c);
    count_n_c = count + CW'(push_ok_c) - CW'(pop_ok_c);
    head_n_c  = head;
    if (pop_ok_c) begin
      if (count > CW'(1))  head_n_c = mem[rd_ptr + AW'(1)];
      else if (push_ok_c)  head_n_c = push_data;
    end else if (empty && push_ok_c) begin
      head_n_c = push_data;
    end
  end

  // Storage array needs no reset; validity is tracked by count.
  always_ff @(posedge clk) begin
    if (push_ok_c) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      head       <= '0;
      head_valid <= 1'b0;
    end else begin
      if (push_ok_c) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok_c)  rd_ptr <= rd_ptr + AW'(1);
      count      <= count_n_c;
      head       <= head_n_c;
      head_valid <= (count_n_c != '0);
    end
  end

endmodule

// File: rtl/notedur_tracker.sv
// Note-duration tracker: filters single-frame pitch glitches, measures the
// committed note length in frames and queues classified events.
// Ports: clk, reset (async active-low), frame_tick/note (one sample per
//        frame), flush (close current note), ev (event stream, master),
//        cur_note/cur_frames (committed note status), overflow (sticky drop).
module notedur_tracker
  import notedur_pkg::*;
#(
  parameter int unsigned NOTE_W        = 8,
  parameter int unsigned CNT_W         = 6,
  parameter int unsigned STABLE_FRAMES = 2,
  parameter int unsigned T_EIGHTH      = 2,
  parameter int unsigned T_QUARTER     = 7,
  parameter int unsigned T_HALF        = 15,
  parameter int unsigned T_WHOLE       = 30,
  parameter int unsigned EMIT_RESTS    = 1,
  parameter int unsigned DEPTH         = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_tick,
  input  logic [NOTE_W-1:0]  note,
  input  logic               flush,
  notedur_tracker_if.master  ev,
  output logic [NOTE_W-1:0]  cur_note,
  output logic [CNT_W-1:0]   cur_frames,
  output logic               overflow
);

  localparam int unsigned      EV_W       = NOTE_W + DUR_W + CNT_W;
  localparam logic [CNT_W-1:0] FRAMES_MAX = '1;
  localparam logic [CNT_W-1:0] STABLE_CNT = CNT_W'(STABLE_FRAMES);

  logic [NOTE_W-1:0] cand_note;
  logic [CNT_W-1:0]  cand_cnt;
  logic [NOTE_W-1:0] cur_note_n_c;
  logic [CNT_W-1:0]  cur_frames_n_c;
  logic [NOTE_W-1:0] cand_note_n_c;
  logic [CNT_W-1:0]  cand_cnt_n_c;
  logic [CNT_W-1:0]  cand_upd_c;
  logic              close_c;
  logic              push_c;
  dur_class_t        dur_c;
  logic [EV_W-1:0]   push_word_c;
  logic [EV_W-1:0]   head;
  logic              head_valid;
  logic              fifo_full;
  logic              fifo_empty;

  // Thresholds are truncated to counter width before comparing.
  assign dur_c = classify(32'(cur_frames), 32'(CNT_W'(T_EIGHTH)), 32'(CNT_W'(T_QUARTER)),
                          32'(CNT_W'(T_HALF)), 32'(CNT_W'(T_WHOLE)));
  assign push_word_c = {cur_note, DUR_W'(dur_c), cur_frames};

  // Next-state for the committed note and the glitch-filter candidate.
  // A candidate count of zero means no candidate is pending.
  always_comb begin
    cur_note_n_c   = cur_note;
    cur_frames_n_c = cur_frames;
    cand_note_n_c  = cand_note;
    cand_cnt_n_c   = cand_cnt;
    cand_upd_c     = '0;
    close_c        = 1'b0;
    if (flush) begin
      close_c        = 1'b1;
      cur_note_n_c   = '0;
      cur_frames_n_c = '0;
      cand_note_n_c  = '0;
      cand_cnt_n_c   = '0;
    end else if (frame_tick) begin
      if (note == cur_note) begin
        if (cur_frames != FRAMES_MAX) cur_frames_n_c = cur_frames + CNT_W'(1);
        cand_cnt_n_c = '0;
      end else begin
        cand_upd_c = (cand_cnt != '0 && note == cand_note) ? cand_cnt + CNT_W'(1) : CNT_W'(1);
        if (cand_upd_c == STABLE_CNT) begin
          close_c        = 1'b1;
          cur_note_n_c   = note;
          cur_frames_n_c = STABLE_CNT;
          cand_cnt_n_c   = '0;
        end else begin
          cand_note_n_c = note;
          cand_cnt_n_c  = cand_upd_c;
        end
      end
    end
    push_c = close_c && (cur_frames != '0) &&
             (EMIT_RESTS != 0 || cur_note != NOTE_W'(REST_CODE));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur_note   <= '0;
      cur_frames <= '0;
      cand_note  <= '0;
      cand_cnt   <= '0;
      overflow   <= 1'b0;
    end else begin
      cur_note   <= cur_note_n_c;
      cur_frames <= cur_frames_n_c;
      cand_note  <= cand_note_n_c;
      cand_cnt   <= cand_cnt_n_c;
      // Drop only when full and the head is not leaving this cycle.
      if (push_c && fifo_full && !(ev.out_ready && !fifo_empty)) overflow <= 1'b1;
    end
  end

  note_event_fifo #(
    .WIDTH (EV_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push_c),
    .push_data  (push_word_c),
    .pop        (ev.out_ready),
    .head       (head),
    .head_valid (head_valid),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  assign ev.out_valid = head_valid;
  assign {ev.out_note, ev.out_dur, ev.out_frames} = head;

endmodule

// File: tb/tb_notedur_tracker.sv
// Bench for notedur_tracker: directed scenarios plus randomized frames
// checked against an event-level reference model of the default instance.
module tb_notedur_tracker;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tick_a, flush_a, tick_b, flush_b;
  logic [7:0] note_a, note_b, cur_note_a, cur_note_b;
  logic [5:0] cur_frames_a, cur_frames_b;
  logic       ovf_a, ovf_b;

  notedur_tracker_if #(.NOTE_W(8), .CNT_W(6)) ev_a ();
  notedur_tracker_if #(.NOTE_W(8), .CNT_W(6)) ev_b ();

  notedur_tracker dut_a (
    .clk(clk), .reset(reset), .frame_tick(tick_a), .note(note_a), .flush(flush_a),
    .ev(ev_a), .cur_note(cur_note_a), .cur_frames(cur_frames_a), .overflow(ovf_a));

  notedur_tracker #(.EMIT_RESTS(0)) dut_b (
    .clk(clk), .reset(reset), .frame_tick(tick_b), .note(note_b), .flush(flush_b),
    .ev(ev_b), .cur_note(cur_note_b), .cur_frames(cur_frames_b), .overflow(ovf_b));

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model of dut_a: committed note, length, candidate, event queue.
  typedef struct { int note; int dur; int frames; } ev_t;
  int  m_cur, m_frames, m_cand, m_ccnt;
  bit  m_ovf;
  ev_t mq[$];

  function automatic int cls(input int f);
    if (f < 2)  return 0;
    if (f < 7)  return 1;
    if (f < 15) return 2;
    if (f < 30) return 4;
    return 8;
  endfunction

  function automatic void model_clear();
    m_cur = 0; m_frames = 0; m_cand = 0; m_ccnt = 0; m_ovf = 0;
    mq.delete();
  endfunction

  // One clock of dut_a with the model advanced from the pre-edge state.
  task automatic step(input bit tk, input int n, input bit fl, input bit rdy);
    ev_t e;
    bit  emit, pop;
    tick_a = tk; note_a = 8'(n); flush_a = fl; ev_a.out_ready = rdy;
    pop  = rdy && (mq.size() > 0);
    emit = 0;
    e.note = m_cur; e.dur = cls(m_frames); e.frames = m_frames;
    if (fl) begin
      emit = (m_frames > 0);
      m_cur = 0; m_frames = 0; m_ccnt = 0;
    end else if (tk) begin
      if (n == m_cur) begin
        m_frames = (m_frames < 63) ? m_frames + 1 : 63;
        m_ccnt = 0;
      end else begin
        if (m_ccnt > 0 && n == m_cand) m_ccnt++;
        else begin m_cand = n; m_ccnt = 1; end
        if (m_ccnt == 2) begin
          emit = (m_frames > 0);
          m_cur = n; m_frames = 2; m_ccnt = 0;
        end
      end
    end
    if (pop) void'(mq.pop_front());
    if (emit) begin
      if (mq.size() < 4) mq.push_back(e);
      else m_ovf = 1;
    end
    @(posedge clk); #1;
    tick_a = 0; flush_a = 0;
  endtask

  task automatic step_b(input bit tk, input int n, input bit fl, input bit rdy);
    tick_b = tk; note_b = 8'(n); flush_b = fl; ev_b.out_ready = rdy;
    @(posedge clk); #1;
    tick_b = 0; flush_b = 0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 0;
    tick_a = 0; flush_a = 0; ev_a.out_ready = 0;
    tick_b = 0; flush_b = 0; ev_b.out_ready = 0;
    model_clear();
    @(negedge clk);
    reset = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    apply_reset();
    n_tests++; if (cur_note_a !== 8'h00) begin n_fail++; $display("FAIL reset_cur_note: got %0h want 0", cur_note_a); end
    n_tests++; if (cur_frames_a !== 6'd0) begin n_fail++; $display("FAIL reset_cur_frames: got %0d want 0", cur_frames_a); end
    n_tests++; if (ev_a.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", ev_a.out_valid); end
    n_tests++; if ({ev_a.out_note, ev_a.out_dur, ev_a.out_frames} !== 18'd0) begin n_fail++; $display("FAIL reset_payload: got %0h want 0", {ev_a.out_note, ev_a.out_dur, ev_a.out_frames}); end
    n_tests++; if (ovf_a !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b want 0", ovf_a); end
  endtask

  task automatic test_stable();
    apply_reset();
    for (int i = 0; i < 10; i++) step(1, 'h21, 0, 0);
    step(1, 'h22, 0, 0);
    n_tests++; if (ev_a.out_valid !== 1'b0) begin n_fail++; $display("FAIL stable_no_early_event: got %b want 0", ev_a.out_valid); end
    n_tests++; if (cur_note_a !== 8'h21) begin n_fail++; $display("FAIL stable_hold_note: got %0h want 21", cur_note_a); end
    step(1, 'h22, 0, 0);
    n_tests++; if (ev_a.out_valid !== 1'b1) begin n_fail++; $display("FAIL stable_out_valid: got %b want 1", ev_a.out_valid); end
    n_tests++; if ({ev_a.out_note, ev_a.out_dur, ev_a.out_frames} !== {8'h21, 4'b0010, 6'd10}) begin n_fail++; $display("FAIL stable_event: got %0h/%b/%0d want 21/0010/10", ev_a.out_note, ev_a.out_dur, ev_a.out_frames); end
    n_tests++; if (cur_note_a !== 8'h22 || cur_frames_a !== 6'd2) begin n_fail++; $display("FAIL stable_commit: got %0h/%0d want 22/2", cur_note_a, cur_frames_a); end
    step(1, 'h22, 0, 1);
    n_tests++; if (ev_a.out_valid !== 1'b0 || cur_frames_a !== 6'd3) begin n_fail++; $display("FAIL stable_pop: got valid %b frames %0d want 0/3", ev_a.out_valid, cur_frames_a); end
  endtask

  task automatic test_glitch();
    int seen = 0;
    apply_reset();
    for (int i = 0; i < 8; i++) step(1, 'h21, 0, 1);
    step(1, 'h30, 0, 1);
    seen += ev_a.out_valid;
    for (int i = 0; i < 5; i++) begin step(1, 'h21, 0, 1); seen += ev_a.out_valid; end
    n_tests++; if (seen !== 0) begin n_fail++; $display("FAIL glitch_no_event: got %0d events want 0", seen); end
    n_tests++; if (cur_note_a !== 8'h21 || cur_frames_a !== 6'd13) begin n_fail++; $display("FAIL glitch_frames: got %0h/%0d want 21/13", cur_note_a, cur_frames_a); end
    step(1, 'h30, 0, 0);
    n_tests++; if (cur_note_a !== 8'h21 || cur_frames_a !== 6'd13) begin n_fail++; $display("FAIL glitch_cand_cleared: got %0h/%0d want 21/13", cur_note_a, cur_frames_a); end
    step(1, 'h21, 0, 0);
    n_tests++; if (cur_frames_a !== 6'd14) begin n_fail++; $display("FAIL glitch_resume: got %0d want 14", cur_frames_a); end
  endtask

  task automatic test_saturation();
    apply_reset();
    for (int i = 0; i < 70; i++) step(1, 'h15, 0, 0);
    n_tests++; if (cur_note_a !== 8'h15 || cur_frames_a !== 6'd63) begin n_fail++; $display("FAIL sat_hold: got %0h/%0d want 15/63", cur_note_a, cur_frames_a); end
    step(0, 0, 1, 0);
    n_tests++; if (ev_a.out_valid !== 1'b1 || {ev_a.out_note, ev_a.out_dur, ev_a.out_frames} !== {8'h15, 4'b1000, 6'd63}) begin n_fail++; $display("FAIL sat_event: got %b %0h/%b/%0d want 1 15/1000/63", ev_a.out_valid, ev_a.out_note, ev_a.out_dur, ev_a.out_frames); end
    n_tests++; if (cur_note_a !== 8'h00 || cur_frames_a !== 6'd0) begin n_fail++; $display("FAIL sat_flush_clear: got %0h/%0d want 0/0", cur_note_a, cur_frames_a); end
  endtask

  task automatic test_rests();
    apply_reset();
    for (int i = 0; i < 3; i++) step_b(1, 'h00, 0, 0);
    n_tests++; if (cur_frames_b !== 6'd3) begin n_fail++; $display("FAIL rest_count: got %0d want 3", cur_frames_b); end
    for (int i = 0; i < 4; i++) step_b(1, 'h40, 0, 0);
    n_tests++; if (ev_b.out_valid !== 1'b0 || cur_note_b !== 8'h40 || cur_frames_b !== 6'd4) begin n_fail++; $display("FAIL rest_initial_suppressed: got %b %0h/%0d want 0 40/4", ev_b.out_valid, cur_note_b, cur_frames_b); end
    for (int i = 0; i < 4; i++) step_b(1, 'h00, 0, 0);
    n_tests++; if (ev_b.out_valid !== 1'b1 || {ev_b.out_note, ev_b.out_dur, ev_b.out_frames} !== {8'h40, 4'b0001, 6'd4}) begin n_fail++; $display("FAIL rest_note_event: got %b %0h/%b/%0d want 1 40/0001/4", ev_b.out_valid, ev_b.out_note, ev_b.out_dur, ev_b.out_frames); end
    step_b(0, 0, 1, 0);
    step_b(0, 0, 0, 1);
    n_tests++; if (ev_b.out_valid !== 1'b0) begin n_fail++; $display("FAIL rest_trailing_suppressed: got %b want 0", ev_b.out_valid); end
  endtask

  task automatic test_overflow(input bit pop_on_fifth);
    int base;
    apply_reset();
    for (int k = 1; k <= 6; k++)
      for (int j = 0; j < 3; j++) step(1, k, 0, pop_on_fifth && k == 6 && j == 1);
    base = pop_on_fifth ? 2 : 1;
    n_tests++; if (ovf_a !== !pop_on_fifth) begin n_fail++; $display("FAIL ovf_flag_%0d: got %b want %b", pop_on_fifth, ovf_a, !pop_on_fifth); end
    for (int k = 0; k < 4; k++) begin
      n_tests++; if (ev_a.out_valid !== 1'b1 || ev_a.out_note !== 8'(base + k) || ev_a.out_frames !== 6'd3 || ev_a.out_dur !== 4'b0001) begin n_fail++; $display("FAIL ovf_drain_%0d_%0d: got %b %0h/%b/%0d want 1 %0h/0001/3", pop_on_fifth, k, ev_a.out_valid, ev_a.out_note, ev_a.out_dur, ev_a.out_frames, base + k); end
      step(0, 0, 0, 1);
    end
    n_tests++; if (ev_a.out_valid !== 1'b0 || ovf_a !== !pop_on_fifth) begin n_fail++; $display("FAIL ovf_empty_%0d: got valid %b ovf %b want 0/%b", pop_on_fifth, ev_a.out_valid, ovf_a, !pop_on_fifth); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    for (int k = 1; k <= 3; k++)
      for (int j = 0; j < 3; j++) step(1, k, 0, 0);
    step(1, 'h09, 0, 0);
    reset = 0;
    #1;
    n_tests++; if (ev_a.out_valid !== 1'b0 || cur_note_a !== 8'h00 || cur_frames_a !== 6'd0 || ev_a.out_note !== 8'h00) begin n_fail++; $display("FAIL midreset_async: got %b %0h/%0d head %0h want 0 0/0 0", ev_a.out_valid, cur_note_a, cur_frames_a, ev_a.out_note); end
    @(negedge clk);
    reset = 1;
    model_clear();
    @(posedge clk); #1;
    step(1, 'h09, 0, 0);
    n_tests++; if (cur_note_a !== 8'h00 || cur_frames_a !== 6'd0 || ev_a.out_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_cand: got %0h/%0d valid %b want 0/0/0", cur_note_a, cur_frames_a, ev_a.out_valid); end
  endtask

  task automatic test_flush_priority();
    apply_reset();
    for (int i = 0; i < 4; i++) step(1, 'h11, 0, 0);
    step(1, 'h11, 1, 0);
    n_tests++; if (ev_a.out_valid !== 1'b1 || {ev_a.out_note, ev_a.out_dur, ev_a.out_frames} !== {8'h11, 4'b0001, 6'd4}) begin n_fail++; $display("FAIL flush_event: got %b %0h/%b/%0d want 1 11/0001/4", ev_a.out_valid, ev_a.out_note, ev_a.out_dur, ev_a.out_frames); end
    n_tests++; if (cur_note_a !== 8'h00 || cur_frames_a !== 6'd0) begin n_fail++; $display("FAIL flush_clear: got %0h/%0d want 0/0", cur_note_a, cur_frames_a); end
    step(0, 0, 0, 1);
    n_tests++; if (ev_a.out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_single: got %b want 0", ev_a.out_valid); end
  endtask

  task automatic test_random();
    int  n = 0;
    bit  tk, fl, rdy;
    apply_reset();
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(3) == 0) n = $urandom_range(3);
      tk  = ($urandom_range(3) != 0);
      fl  = ($urandom_range(39) == 0);
      rdy = ($urandom_range(2) == 0);
      step(tk, n, fl, rdy);
      n_tests++; if (cur_note_a !== 8'(m_cur) || cur_frames_a !== 6'(m_frames)) begin n_fail++; $display("FAIL rand_cur_%0d: got %0h/%0d want %0h/%0d", c, cur_note_a, cur_frames_a, m_cur, m_frames); end
      n_tests++; if (ev_a.out_valid !== (mq.size() > 0)) begin n_fail++; $display("FAIL rand_valid_%0d: got %b want %b", c, ev_a.out_valid, mq.size() > 0); end
      if (mq.size() > 0) begin
        n_tests++; if (ev_a.out_note !== 8'(mq[0].note) || ev_a.out_dur !== 4'(mq[0].dur) || ev_a.out_frames !== 6'(mq[0].frames)) begin n_fail++; $display("FAIL rand_head_%0d: got %0h/%b/%0d want %0h/%b/%0d", c, ev_a.out_note, ev_a.out_dur, ev_a.out_frames, mq[0].note, 4'(mq[0].dur), mq[0].frames); end
      end
      n_tests++; if (ovf_a !== m_ovf) begin n_fail++; $display("FAIL rand_ovf_%0d: got %b want %b", c, ovf_a, m_ovf); end
    end
  endtask

  initial begin
    tick_a = 0; flush_a = 0; note_a = '0; ev_a.out_ready = 0;
    tick_b = 0; flush_b = 0; note_b = '0; ev_b.out_ready = 0;
    model_clear();
    test_reset();
    test_stable();
    test_glitch();
    test_saturation();
    test_rests();
    test_overflow(0);
    test_overflow(1);
    test_reset_mid();
    test_flush_priority();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
